// File: rtl/sbus_ram_slave_if.sv
// Simple-bus connection between a master (core port) and a responder.
interface sbus;
    logic        en;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data_w;
    logic        pause;
    logic [31:0] data_r;
    logic        stall;

    modport master (
        output en, we, size, addr, data_w, pause,
        input  data_r, stall
    );

    modport slave (
        input  en, we, size, addr, data_w, pause,
        output data_r, stall
    );
endinterface

// File: rtl/sbus_ram_slave.sv
// Word-organised on-chip RAM responding on the sbus, with a fixed number
// of wait states per request and a read-data holding register.
module sbus_ram_slave #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input logic clk,
    input logic rst,
    sbus.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LOAD = 4'((LATENCY == 0) ? 0 : LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;
    logic [3:0] cnt;

    logic           req_we;
    logic [1:0]     req_size;
    logic [AW+1:0]  req_addr;
    logic [31:0]    req_data;

    logic           cur_we;
    logic [1:0]     cur_size;
    logic [AW+1:0]  cur_addr;
    logic [31:0]    cur_data;
    logic [AW-1:0]  idx;
    logic [3:0]     be;
    logic           commit;
    logic [31:0]    data_r;

    logic [31:0] mem [DEPTH_WORDS];

    // Address bits above the RAM range alias and are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.addr[31:AW+2];

    // In IDLE a zero-latency request commits straight from the bus; in any
    // other state the operation works from the copy latched at acceptance.
    always_comb begin
        if (state == IDLE) begin
            cur_we   = bus.we;
            cur_size = bus.size;
            cur_addr = bus.addr[AW+1:0];
            cur_data = bus.data_w;
        end else begin
            cur_we   = req_we;
            cur_size = req_size;
            cur_addr = req_addr;
            cur_data = req_data;
        end
    end

    assign idx = cur_addr[AW+1:2];

    // Commit happens on the edge that enters DONE; never while in reset so
    // that an interrupted write leaves the RAM untouched.
    assign commit = !rst && (((state == IDLE) && bus.en && (LATENCY == 0)) ||
                             ((state == BUSY) && (cnt == 4'd0)));

    // Byte lanes for a write; misaligned halves and words enable nothing.
    always_comb begin
        be = 4'b0000;
        case (cur_size)
            2'b00:   be[cur_addr[1:0]] = 1'b1;
            2'b01:   if (!cur_addr[0]) be = cur_addr[1] ? 4'b1100 : 4'b0011;
            default: if (cur_addr[1:0] == 2'b00) be = 4'b1111;
        endcase
    end

    // Next state and stall: stall covers acceptance and all wait states.
    always_comb begin
        state_next = state;
        bus.stall  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.en) begin
                    bus.stall  = 1'b1;
                    state_next = (LATENCY == 0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                bus.stall = 1'b1;
                if (cnt == 4'd0) state_next = DONE;
            end
            DONE: begin
                if (!bus.pause) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (rst) bus.stall = 1'b0;
    end

    // State register, wait-state counter and request latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            req_we   <= 1'b0;
            req_size <= 2'b00;
            req_addr <= '0;
            req_data <= 32'h0;
        end else begin
            state <= state_next;
            if (state == IDLE && bus.en) begin
                req_we   <= bus.we;
                req_size <= bus.size;
                req_addr <= bus.addr[AW+1:0];
                req_data <= bus.data_w;
                cnt      <= LOAD;
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // RAM array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (commit && cur_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][i*8 +: 8] <= cur_data[i*8 +: 8];
            end
        end
    end

    // Read-data holding register, only updated by a read commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r <= 32'h0;
        end else if (commit && !cur_we) begin
            data_r <= mem[idx];
        end
    end

    assign bus.data_r = data_r;
endmodule

// File: tb/tb_sbus_ram_slave.sv
// Directed bench for sbus_ram_slave: one instance with two wait states,
// one with zero wait states and a 16-word RAM for aliasing.
module tb_sbus_ram_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    sbus bus_a();
    sbus bus_b();

    sbus_ram_slave #(.DEPTH_WORDS(1024), .LATENCY(2)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    sbus_ram_slave #(.DEPTH_WORDS(16), .LATENCY(0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    always #5 clk = ~clk;

    function automatic logic get_stall(input bit sel);
        return sel ? bus_b.stall : bus_a.stall;
    endfunction

    function automatic logic [31:0] get_data(input bit sel);
        return sel ? bus_b.data_r : bus_a.data_r;
    endfunction

    task automatic drive(input bit sel, input logic en, input logic we,
                         input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] data);
        if (sel) begin
            bus_b.en = en; bus_b.we = we; bus_b.size = size;
            bus_b.addr = addr; bus_b.data_w = data;
        end else begin
            bus_a.en = en; bus_a.we = we; bus_a.size = size;
            bus_a.addr = addr; bus_a.data_w = data;
        end
    endtask

    task automatic set_en(input bit sel, input logic en);
        if (sel) bus_b.en = en;
        else     bus_a.en = en;
    endtask

    // Issues one request, counts stall cycles and returns data_r sampled in
    // the first cycle with stall low.
    task automatic do_req(input bit sel, input logic we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] data,
                          output int stall_cycles, output logic [31:0] rdata);
        @(posedge clk); #1;
        drive(sel, 1'b1, we, size, addr, data);
        stall_cycles = 0;
        @(negedge clk);
        if (get_stall(sel)) stall_cycles++;
        @(posedge clk); #1;
        set_en(sel, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (get_stall(sel)) stall_cycles++;
            else break;
        end
        rdata = get_data(sel);
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (bus_a.stall !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_stall_a: got %b want 0", bus_a.stall);
        end
        checks++;
        if (bus_a.data_r !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_data_a: got %h want 00000000", bus_a.data_r);
        end
        checks++;
        if (bus_b.stall !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_stall_b: got %b want 0", bus_b.stall);
        end
        checks++;
        if (bus_b.data_r !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_data_b: got %h want 00000000", bus_b.data_r);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_word_rw();
        int sc;
        logic [31:0] rd;
        do_req(1'b0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, sc, rd);
        checks++;
        if (sc !== 3) begin
            errors++; $display("[TB] FAIL word_write_stall: got %0d cycles want 3", sc);
        end
        do_req(1'b0, 1'b0, 2'b10, 32'h10, 32'h0, sc, rd);
        checks++;
        if (sc !== 3) begin
            errors++; $display("[TB] FAIL word_read_stall: got %0d cycles want 3", sc);
        end
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++; $display("[TB] FAIL word_read_data: got %h want DEADBEEF", rd);
        end
    endtask

    task automatic test_byte_half();
        int sc;
        logic [31:0] rd;
        do_req(1'b0, 1'b1, 2'b10, 32'h20, 32'h00000000, sc, rd);
        do_req(1'b0, 1'b1, 2'b00, 32'h22, 32'h00AB0000, sc, rd);
        do_req(1'b0, 1'b1, 2'b01, 32'h20, 32'h0000CDEF, sc, rd);
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++; $display("[TB] FAIL data_r_held_over_writes: got %h want DEADBEEF", rd);
        end
        do_req(1'b0, 1'b0, 2'b10, 32'h20, 32'h0, sc, rd);
        checks++;
        if (rd !== 32'h00ABCDEF) begin
            errors++; $display("[TB] FAIL byte_half_merge: got %h want 00ABCDEF", rd);
        end
    endtask

    task automatic test_misaligned();
        int sc;
        logic [31:0] rd;
        do_req(1'b0, 1'b1, 2'b10, 32'h20, 32'h12345678, sc, rd);
        do_req(1'b0, 1'b1, 2'b01, 32'h21, 32'hFFFFFFFF, sc, rd);
        checks++;
        if (sc !== 3) begin
            errors++; $display("[TB] FAIL misaligned_stall: got %0d cycles want 3", sc);
        end
        do_req(1'b0, 1'b1, 2'b10, 32'h23, 32'hFFFFFFFF, sc, rd);
        do_req(1'b0, 1'b0, 2'b10, 32'h21, 32'h0, sc, rd);
        checks++;
        if (rd !== 32'h12345678) begin
            errors++; $display("[TB] FAIL misaligned_suppressed: got %h want 12345678", rd);
        end
    endtask

    task automatic test_pause();
        int sc;
        logic [31:0] rd;
        do_req(1'b0, 1'b1, 2'b10, 32'h38, 32'hCAFEF00D, sc, rd);
        do_req(1'b0, 1'b1, 2'b10, 32'h40, 32'h77777777, sc, rd);
        do_req(1'b0, 1'b0, 2'b10, 32'h38, 32'h0, sc, rd);
        bus_a.pause = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 2'b10, 32'h40, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus_a.stall !== 1'b0) begin
                errors++; $display("[TB] FAIL pause_stall[%0d]: got %b want 0", i, bus_a.stall);
            end
            checks++;
            if (bus_a.data_r !== 32'hCAFEF00D) begin
                errors++; $display("[TB] FAIL pause_data[%0d]: got %h want CAFEF00D", i, bus_a.data_r);
            end
        end
        bus_a.pause = 1'b0;
        @(negedge clk);
        sc = 0;
        checks++;
        if (bus_a.stall !== 1'b1) begin
            errors++; $display("[TB] FAIL pause_release_accept: got %b want 1", bus_a.stall);
        end
        if (bus_a.stall) sc++;
        @(posedge clk); #1;
        bus_a.en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_a.stall) sc++;
            else break;
        end
        checks++;
        if (sc !== 3) begin
            errors++; $display("[TB] FAIL after_pause_stall: got %0d cycles want 3", sc);
        end
        checks++;
        if (bus_a.data_r !== 32'h77777777) begin
            errors++; $display("[TB] FAIL after_pause_data: got %h want 77777777", bus_a.data_r);
        end
    endtask

    task automatic test_reset_mid_busy();
        int sc;
        logic [31:0] rd;
        do_req(1'b0, 1'b1, 2'b10, 32'h30, 32'h22222222, sc, rd);
        do_req(1'b0, 1'b0, 2'b10, 32'h30, 32'h0, sc, rd);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 2'b10, 32'h30, 32'h11111111);
        @(posedge clk); #1;
        bus_a.en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus_a.stall !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_busy_stall: got %b want 0", bus_a.stall);
        end
        checks++;
        if (bus_a.data_r !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_busy_data: got %h want 00000000", bus_a.data_r);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        do_req(1'b0, 1'b0, 2'b10, 32'h30, 32'h0, sc, rd);
        checks++;
        if (rd !== 32'h22222222) begin
            errors++; $display("[TB] FAIL reset_discards_write: got %h want 22222222", rd);
        end
    endtask

    task automatic test_latency0_alias();
        int sc;
        logic [31:0] rd;
        do_req(1'b1, 1'b1, 2'b10, 32'h04, 32'h5A5A5A5A, sc, rd);
        checks++;
        if (sc !== 1) begin
            errors++; $display("[TB] FAIL lat0_write_stall: got %0d cycles want 1", sc);
        end
        do_req(1'b1, 1'b0, 2'b10, 32'h44, 32'h0, sc, rd);
        checks++;
        if (sc !== 1) begin
            errors++; $display("[TB] FAIL lat0_read_stall: got %0d cycles want 1", sc);
        end
        checks++;
        if (rd !== 32'h5A5A5A5A) begin
            errors++; $display("[TB] FAIL lat0_alias_data: got %h want 5A5A5A5A", rd);
        end
    endtask

    // Runs every scenario in order and prints the summary.
    initial begin
        drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        bus_a.pause = 1'b0;
        bus_b.pause = 1'b0;
        test_reset();
        test_word_rw();
        test_byte_half();
        test_misaligned();
        test_pause();
        test_reset_mid_busy();
        test_latency0_alias();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
